// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle signed restoring divider for the ALU DIV path.
// Dividend comes from Y, divisor from the bus; quotient goes to LO, remainder to HI.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; operands captured on the start edge
// S_SETUP | take operand magnitudes, record result signs, clear remainder
// S_ITER  | one restoring step per cycle, MSB first, WIDTH cycles
// S_FIX   | apply signs (or divide-by-zero result), load output registers
// S_DONE  | one-cycle done pulse, then back to idle
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // captured dividend
  logic [WIDTH-1:0] dvs_q, dvs_d;     // captured divisor
  logic [WIDTH-1:0] mag_q, mag_d;     // dividend magnitude, shifts out as quotient bits shift in
  logic [WIDTH-1:0] dmag_q, dmag_d;   // divisor magnitude
  // The stored partial remainder is always below the divisor magnitude, so it
  // fits in WIDTH bits; only the shifted trial value needs the extra bit.
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH:0]   trial;

  // Next-state, datapath and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    mag_d   = mag_q;
    dmag_d  = dmag_q;
    prem_d  = prem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    prem_sh = {prem_q, mag_q[WIDTH-1]};
    trial   = prem_sh - {1'b0, dmag_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        busy_o  = 1'b1;
        mag_d   = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
        dmag_d  = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        qsign_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
        rsign_d = dvd_q[WIDTH-1];
        prem_d  = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        busy_o = 1'b1;
        if (!trial[WIDTH]) begin
          prem_d = trial[WIDTH-1:0];
          mag_d  = {mag_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = prem_sh[WIDTH-1:0];
          mag_d  = {mag_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        busy_o = 1'b1;
        // Divide by zero falls through the iterations normally so latency is
        // unchanged; its result is substituted here.
        if (dvs_q == '0) begin
          quo_d = '1;
          rem_d = dvd_q;
          dz_d  = 1'b1;
        end else begin
          quo_d = qsign_q ? -mag_q : mag_q;
          rem_d = rsign_q ? -prem_q : prem_q;
          dz_d  = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mag_q   <= '0;
      dmag_q  <= '0;
      prem_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mag_q   <= mag_d;
      dmag_q  <= dmag_d;
      prem_q  <= prem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule
